// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - programmable N-step note sequencer with tempo divider, live record and gate length
module step_sequencer #(
    parameter int N_STEPS  = 8,
    parameter int NOTE_W   = 4,
    parameter int BEAT_DIV = 2500,
    parameter int GATE_DIV = 1250,
    localparam int STEP_W  = $clog2(N_STEPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_STEPS-1:0]  step_keys,
    input  logic                seq_on_key,
    input  logic                play_key,
    input  logic                rec_en,
    input  logic [NOTE_W-1:0]   live_note,
    output logic [NOTE_W-1:0]   note_out,
    output logic                gate,
    output logic                sequencer_on,
    output logic                playing,
    output logic [STEP_W-1:0]   step,
    output logic [N_STEPS-1:0]  step_led,
    output logic [N_STEPS-1:0]  enable_mask
);

    localparam int KEY_W = N_STEPS + 2;
    // Wide enough to hold GATE_DIV == BEAT_DIV for the gate comparison.
    localparam int DIV_W = $clog2(BEAT_DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BEAT_DIV - 1);
    localparam logic [DIV_W-1:0]  GATE_LIM  = DIV_W'(GATE_DIV);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

    typedef enum logic [1:0] {S_OFF, S_PAUSED, S_PLAYING} state_t;

    state_t             state, state_next;
    logic [KEY_W-1:0]   key_raw, sync1, sync2, sync3, key_edge;
    logic [N_STEPS-1:0] step_edge, mask_next;
    logic               seq_edge, play_edge, rec_fire, sounding;
    logic [DIV_W-1:0]   div_cnt;
    logic [NOTE_W-1:0]  note_mem [N_STEPS];
    logic [NOTE_W-1:0]  cur_note;

    assign key_raw = {play_key, seq_on_key, step_keys};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign key_edge  = sync2 & ~sync3;
    assign step_edge = key_edge[N_STEPS-1:0];
    assign seq_edge  = key_edge[N_STEPS];
    assign play_edge = key_edge[N_STEPS+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_OFF;
        else     state <= state_next;
    end

    // seq_on_key takes priority; a coincident play_key edge is dropped.
    always_comb begin
        state_next = state;
        case (state)
            S_OFF: begin
                if (seq_edge) state_next = S_PAUSED;
            end
            S_PAUSED: begin
                if (seq_edge)       state_next = S_OFF;
                else if (play_edge) state_next = S_PLAYING;
            end
            S_PLAYING: begin
                if (seq_edge)       state_next = S_OFF;
                else if (play_edge) state_next = S_PAUSED;
            end
            default: state_next = S_OFF;
        endcase
    end

    // The divider only runs on cycles that stay in PLAYING, so a pause holds the exact position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            step    <= '0;
        end else if (state_next == S_OFF) begin
            div_cnt <= '0;
            step    <= '0;
        end else if (state == S_PLAYING && state_next == S_PLAYING) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                step    <= (step == LAST_STEP) ? '0 : step + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign rec_fire = (state == S_PLAYING) && rec_en && (div_cnt == '0) && (live_note != '0);

    always_comb begin
        mask_next = enable_mask ^ step_edge;
        if (rec_fire) mask_next[step] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) enable_mask <= '0;
        else     enable_mask <= mask_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_STEPS; i++)
                note_mem[i] <= NOTE_W'((i % ((1 << NOTE_W) - 1)) + 1);
        end else if (rec_fire) begin
            note_mem[step] <= live_note;
        end
    end

    assign cur_note     = note_mem[step];
    assign sounding     = (state == S_PLAYING) && enable_mask[step] &&
                          (cur_note != '0) && (div_cnt < GATE_LIM);
    assign note_out     = sounding ? cur_note : '0;
    assign gate         = sounding;
    assign sequencer_on = (state != S_OFF);
    assign playing      = (state == S_PLAYING);
    assign step_led     = sequencer_on ? (N_STEPS'(1) << step) : '0;

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - self-checking bench for step_sequencer against a position-based reference model
module tb_step_sequencer;

    localparam int NS = 4;
    localparam int NW = 4;
    localparam int BD = 4;
    localparam int GD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] step_keys;
    logic          seq_on_key, play_key, rec_en;
    logic [NW-1:0] live_note;
    logic [NW-1:0] note_out;
    logic          gate, sequencer_on, playing;
    logic [1:0]    step;
    logic [NS-1:0] step_led, enable_mask;

    int total = 0;
    int bad   = 0;

    // Reference model: one absolute position counter across the whole pattern.
    int m_on, m_play, m_pos;
    int m_en   [NS];
    int m_note [NS];
    logic [NS+1:0] h1, h2, h3;

    step_sequencer #(.N_STEPS(NS), .NOTE_W(NW), .BEAT_DIV(BD), .GATE_DIV(GD)) dut (
        .clk(clk), .rst(rst), .step_keys(step_keys), .seq_on_key(seq_on_key),
        .play_key(play_key), .rec_en(rec_en), .live_note(live_note),
        .note_out(note_out), .gate(gate), .sequencer_on(sequencer_on),
        .playing(playing), .step(step), .step_led(step_led), .enable_mask(enable_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_play = 0; m_pos = 0;
        h1 = '0; h2 = '0; h3 = '0;
        for (int i = 0; i < NS; i++) begin
            m_en[i]   = 0;
            m_note[i] = (i % 15) + 1;
        end
    endtask

    task automatic model_step();
        logic [NS+1:0] e;
        int st;
        bit rec;
        e   = h2 & ~h3;
        st  = m_pos / BD;
        rec = m_play != 0 && rec_en && (m_pos % BD) == 0 && live_note != 0;
        if (e[NS]) begin
            if (m_on == 0) m_on = 1;
            else begin m_on = 0; m_play = 0; m_pos = 0; end
        end else if (e[NS+1] && m_on != 0) begin
            m_play = !m_play;
        end else if (m_play != 0) begin
            m_pos = (m_pos + 1) % (NS * BD);
        end
        for (int i = 0; i < NS; i++)
            if (e[i]) m_en[i] = !m_en[i];
        if (rec) begin
            m_en[st]   = 1;
            m_note[st] = live_note;
        end
        h3 = h2; h2 = h1; h1 = {play_key, seq_on_key, step_keys};
    endtask

    task automatic check_all();
        int st, dv, exp_note;
        logic [NS-1:0] exp_mask;
        st = m_pos / BD;
        dv = m_pos % BD;
        exp_note = (m_play != 0 && m_en[st] != 0 && m_note[st] != 0 && dv < GD) ? m_note[st] : 0;
        for (int i = 0; i < NS; i++) exp_mask[i] = m_en[i][0];
        chk("note_out", 32'(note_out), 32'(exp_note));
        chk("gate", 32'(gate), 32'(exp_note != 0));
        chk("step", 32'(step), 32'(st));
        chk("playing", 32'(playing), 32'(m_play));
        chk("sequencer_on", 32'(sequencer_on), 32'(m_on));
        chk("step_led", 32'(step_led), (m_on != 0) ? 32'(1 << st) : 32'd0);
        chk("enable_mask", 32'(enable_mask), 32'(exp_mask));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check_all();
    endtask

    task automatic pulse_keys(input logic s, input logic p);
        seq_on_key = s; play_key = p;
        tick();
        seq_on_key = 0; play_key = 0;
        tick();
        tick();
    endtask

    // Returns at the first cycle of step s (div_cnt 0), never mid-step.
    task automatic wait_step(input int s);
        int n = 0;
        while (32'(step) == 32'(s) && n < 40) begin tick(); n++; end
        while (32'(step) != 32'(s) && n < 80) begin tick(); n++; end
        chk("wait_step", 32'(step), 32'(s));
    endtask

    initial begin
        int n;
        logic [3:0] exp_seq [16];
        exp_seq = '{1, 1, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0};

        rst = 1; step_keys = '0; seq_on_key = 0; play_key = 0; rec_en = 0; live_note = '0;
        model_reset();
        tick(); tick();
        rst = 0;
        repeat (3) tick();
        chk("idle_led", 32'(step_led), 0);
        chk("idle_mask", 32'(enable_mask), 0);
        chk("idle_on", 32'(sequencer_on), 0);

        // program 0101 in OFF, then switch on and play
        step_keys = 4'b0101; tick(); step_keys = 4'b0000; tick(); tick();
        chk("prog_mask", 32'(enable_mask), 32'b0101);
        pulse_keys(1, 0);
        play_key = 1; tick(); play_key = 0;
        n = 0;
        while (!playing && n < 20) begin tick(); n++; end
        chk("wait_play", 32'(playing), 1);
        for (int k = 0; k < 16; k++) begin
            if (k != 0) tick();
            chk($sformatf("seq%0d", k), 32'(note_out), 32'(exp_seq[k]));
        end

        // pause at step 2 / div 1, then resume mid-step
        repeat (8) tick();
        pulse_keys(0, 1);
        chk("pause_play", 32'(playing), 0);
        chk("pause_step", 32'(step), 2);
        chk("pause_note", 32'(note_out), 0);
        repeat (5) tick();
        chk("pause_hold", 32'(step), 2);
        pulse_keys(0, 1);
        chk("resume_play", 32'(playing), 1);
        chk("resume_note", 32'(note_out), 3);
        n = 0;
        while (step == 2 && n < 10) begin tick(); n++; end
        chk("resume_len", 32'(n), 3);

        // seq_on and play together while paused: off wins
        pulse_keys(0, 1);
        pulse_keys(1, 1);
        chk("off_on", 32'(sequencer_on), 0);
        chk("off_step", 32'(step), 0);
        chk("off_led", 32'(step_led), 0);
        chk("off_mask", 32'(enable_mask), 32'b0101);
        pulse_keys(1, 0);
        chk("on_led", 32'(step_led), 32'b0001);
        pulse_keys(0, 1);
        chk("replay", 32'(playing), 1);

        // live record into disabled step 1
        wait_step(1);
        rec_en = 1; live_note = 4'd9;
        tick();
        rec_en = 0; live_note = '0;
        chk("rec_mask", 32'(enable_mask), 32'b0111);
        chk("rec_note", 32'(note_out), 9);
        wait_step(0);
        wait_step(1);
        chk("rec_replay", 32'(note_out), 9);

        // held key gives one toggle after three edges
        step_keys = 4'b1000;
        tick(); tick();
        chk("hold_lat", 32'(enable_mask), 32'b0111);
        tick();
        chk("hold_tog", 32'(enable_mask), 32'b1111);
        repeat (17) tick();
        chk("hold_once", 32'(enable_mask), 32'b1111);
        step_keys = '0;
        repeat (3) tick();

        // toggle edge coincident with record on step 3
        wait_step(2);
        tick(); tick();
        step_keys = 4'b1000;
        tick(); tick();
        chk("coin_step", 32'(step), 3);
        rec_en = 1; live_note = 4'd5;
        tick();
        rec_en = 0; live_note = '0; step_keys = '0;
        chk("coin_mask", 32'(enable_mask), 32'b1111);
        chk("coin_note", 32'(note_out), 5);
        repeat (4) tick();

        // asynchronous reset mid-PLAYING
        rst = 1;
        #1;
        chk("ar_note", 32'(note_out), 0);
        chk("ar_gate", 32'(gate), 0);
        chk("ar_on", 32'(sequencer_on), 0);
        chk("ar_play", 32'(playing), 0);
        chk("ar_step", 32'(step), 0);
        chk("ar_led", 32'(step_led), 0);
        chk("ar_mask", 32'(enable_mask), 0);
        model_reset();
        tick();
        rst = 0;
        tick();

        // randomized key/record traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 9) == 0)  step_keys = step_keys ^ NS'(1 << $urandom_range(0, NS - 1));
            if ($urandom_range(0, 79) == 0) seq_on_key = ~seq_on_key;
            if ($urandom_range(0, 19) == 0) play_key = ~play_key;
            if ($urandom_range(0, 11) == 0) rec_en = ~rec_en;
            if ($urandom_range(0, 5) == 0)  live_note = NW'($urandom_range(0, 15));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Parametrised step sequencer: N_STEPS programmable steps, each holding an enable bit and a NOTE_W-bit note code.
- An internal tempo divider advances the steps. The current step's note is gated onto note_out for part of each step.
- Adds live record, pause-in-place and configurable gate length.
- Sits between the keypad decoder and the oscillator/note-select logic; note_out feeds the same note bus as live play.

Parameters:
N_STEPS, 8, number of steps (2..16)
NOTE_W, 4, note code width; code 0 = rest/silence
BEAT_DIV, 2500, clk cycles per step (10 kHz clk -> 4 steps/s); >= 2
GATE_DIV, 1250, cycles the note sounds at the start of each step; 1 <= GATE_DIV <= BEAT_DIV
STEP_W, $clog2(N_STEPS), step index width (derived; not overridden)

Ports:
clk  in  1  system clock (10 kHz nominal)
rst  in  1  asynchronous reset, active-high
step_keys  in  N_STEPS  raw step buttons; each rising edge toggles that step's enable
seq_on_key  in  1  raw button; rising edge toggles sequencer on/off
play_key  in  1  raw button; rising edge toggles play/pause
rec_en  in  1  level; record mode while high
live_note  in  NOTE_W  note currently played live; 0 = none
note_out  out  NOTE_W  sequenced note; 0 when silent
gate  out  1  high while note_out is non-zero and sounding
sequencer_on  out  1  high in PAUSED or PLAYING
playing  out  1  high in PLAYING
step  out  STEP_W  current step index
step_led  out  N_STEPS  one-hot of step when sequencer_on, else all 0
enable_mask  out  N_STEPS  current step enable bits

Behaviour:
- Reset (rst high, asynchronous):
  - State OFF, step=0, div_cnt=0, enable_mask=0.
  - note_mem[i] = (i mod (2^NOTE_W-1))+1.
  - All outputs 0.
  - Takes effect immediately, including mid-step; there is no partial-state recovery.
- Key conditioning:
  - Every raw key passes through a 2-FF synchroniser and a registered rising-edge detector.
  - A key high from cycle t changes state registers at the edge ending cycle t+2. Fixed 3-cycle latency.
  - A held key produces exactly one edge. There is no debounce; upstream handles it.
- State machine (OFF, PAUSED, PLAYING):
  - OFF -seq_on_key-> PAUSED.
  - PAUSED -play_key-> PLAYING.
  - PLAYING -play_key-> PAUSED.
  - PAUSED or PLAYING -seq_on_key-> OFF.
  - Entering OFF clears step and div_cnt. It never clears enable_mask or note_mem.
  - seq_on_key and play_key edges in the same cycle: seq_on_key wins; play_key is dropped.
  - play_key in OFF is ignored.
- Divider:
  - div_cnt counts 0..BEAT_DIV-1 only in PLAYING.
  - At BEAT_DIV-1 it wraps to 0 and step increments, wrapping N_STEPS-1 -> 0.
  - PAUSED holds div_cnt and step, so resume continues mid-step.
  - The first step after PAUSED->PLAYING from OFF starts at step 0, div_cnt 0.
- Output (combinational from registers):
  - In PLAYING with enable_mask[step]=1, note_mem[step]!=0 and div_cnt<GATE_DIV: note_out=note_mem[step], gate=1.
  - Otherwise note_out=0, gate=0.
  - GATE_DIV==BEAT_DIV gives continuous legato.
- Step toggles:
  - Accepted in all states, including OFF.
  - Simultaneous edges on several keys toggle each bit independently.
- Record:
  - Fires in PLAYING when rec_en=1, div_cnt==0 and live_note!=0.
  - Writes note_mem[step]<=live_note and enable_mask[step]<=1.
  - If the same step's toggle edge lands in that cycle, record wins (bit ends at 1).
  - Record never fires in PAUSED or OFF.
  - The write is visible on note_out in the next cycle, at div_cnt 1, if GATE_DIV>1.

Test Plan:
(Bench params: N_STEPS=4, NOTE_W=4, BEAT_DIV=4, GATE_DIV=2.)
- Reset then idle: step_led=0, note_out=0, enable_mask=0000, sequencer_on=0; pulse rst mid-PLAYING -> all outputs 0 the same cycle.
- Toggle step_keys=0101 in OFF, seq_on_key, play_key -> step cycles 0,1,2,3,0 every 4 clks; note_out=1 for 2 clks at step 0, 0 at step 1, 3 for 2 clks at step 2, 0 at step 3.
- play_key at step 2, div_cnt 1 -> playing=0, note_out=0, step holds 2; second play_key -> resumes at div_cnt 1, remaining step length 3 clks.
- seq_on_key and play_key pressed in the same cycle while PAUSED -> state OFF, step=0, step_led=0000, enable_mask unchanged.
- rec_en=1, live_note=9 while PLAYING at step 1 (enable 0) -> enable_mask[1]=1, note_out=9 on the next cycle; step 1 plays 9 on every later pass.
- step_keys[3] held 20 cycles -> exactly one toggle, after 3-cycle latency; toggle edge coincident with record on step 3 -> enable_mask[3]=1.
